pooling_window_serializer: RTL and testbench

- Parametrised successor of the pooling-layer input stage. Accepts one KERNEL_SIZE-word row slice per channel in parallel and emits it serially, one word per cycle, to the pooling comparator.
- Adds over the previous generation: CHANNELS parallel lanes, a ready/valid handshake on both sides, a one-deep holding buffer for back-to-back rows, a block-index tag, a last-word flag and synchronous flush.
- Sits between the conv-layer output buffer and pooling_max_unit.

---
 rtl/pooling_pkg.sv | 10 +
 rtl/pooling_lane_shifter.sv | 34 +++
 rtl/pooling_window_serializer.sv | 119 +++++++++++
 tb/tb_pooling_window_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared defaults and word/row types for the pooling-layer input path.
package pooling_pkg;
    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned KERNEL_SIZE_DEF = 2;
    localparam int unsigned CHANNELS_DEF    = 4;
    localparam int unsigned IDX_WIDTH_DEF   = 3;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef word_t [KERNEL_SIZE_DEF-1:0] row_t;
endpackage

// File: rtl/pooling_lane_shifter.sv
// One lane's row register: load a full row, shift toward word 0, zero-fill the tail.
module pooling_lane_shifter
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              load,
    input  logic                              shift,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] load_row,
    output logic [DATA_WIDTH-1:0]             head
);
    localparam int unsigned ROW_W = KERNEL_SIZE * DATA_WIDTH;

    // Word 0 lives in the MS slice, so a left shift advances to the next word.
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (clear) begin
            row_q <= '0;
        end else if (load) begin
            row_q <= load_row;
        end else if (shift) begin
            row_q <= row_q << DATA_WIDTH;
        end
    end

    assign head = row_q[ROW_W-1 -: DATA_WIDTH];
endmodule

// File: rtl/pooling_window_serializer.sv
// Serialises a KERNEL_SIZE-word row per lane into one word per cycle, with a one-row hold buffer.
module pooling_window_serializer
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int unsigned CHANNELS    = CHANNELS_DEF,
    parameter int unsigned IDX_WIDTH   = IDX_WIDTH_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       flush,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [IDX_WIDTH-1:0]                       in_idx,
    input  logic [CHANNELS*KERNEL_SIZE*DATA_WIDTH-1:0] data_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0]             out_data,
    output logic [IDX_WIDTH-1:0]                       out_idx,
    output logic                                       out_first,
    output logic                                       out_last
);
    localparam int unsigned ROW_W = KERNEL_SIZE * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(KERNEL_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_SIZE - 1);

    typedef enum logic {StEmpty, StEmit} state_t;

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [IDX_WIDTH-1:0]        idx_q;
    logic [CHANNELS*ROW_W-1:0]   hold_q;
    logic [IDX_WIDTH-1:0]        hold_idx_q;
    logic                        hold_full_q;

    logic fire, at_last, row_done, accept, bypass, park, from_hold;
    logic lane_clear, lane_load, lane_shift;

    always_comb begin
        fire      = (state_q == StEmit) && out_ready;
        at_last   = (cnt_q == CNT_LAST);
        row_done  = fire && at_last;
        accept    = in_valid && !hold_full_q && !flush;
        bypass    = accept && ((state_q == StEmpty) || row_done);
        park      = accept && !bypass;
        from_hold = row_done && hold_full_q && !flush;
        // Lane clear outranks load, so flush wins even on a reload cycle.
        lane_clear = flush || (row_done && !hold_full_q && !bypass);
        lane_load  = bypass || from_hold;
        lane_shift = fire && !at_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            hold_idx_q  <= '0;
            hold_full_q <= 1'b0;
        end else if (flush) begin
            state_q     <= StEmpty;
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            hold_idx_q  <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (park) begin
                hold_q      <= data_in;
                hold_idx_q  <= in_idx;
                hold_full_q <= 1'b1;
            end
            if (from_hold) begin
                hold_q      <= '0;
                hold_idx_q  <= '0;
                hold_full_q <= 1'b0;
                state_q     <= StEmit;
                cnt_q       <= '0;
                idx_q       <= hold_idx_q;
            end else if (bypass) begin
                state_q <= StEmit;
                cnt_q   <= '0;
                idx_q   <= in_idx;
            end else if (row_done) begin
                state_q <= StEmpty;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else if (lane_shift) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = !hold_full_q;
    assign out_valid = (state_q == StEmit);
    assign out_idx   = idx_q;
    assign out_first = out_valid && (cnt_q == '0);
    assign out_last  = out_valid && at_last;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [ROW_W-1:0] lane_row;
        assign lane_row = hold_full_q ? hold_q[(CHANNELS-c)*ROW_W-1 -: ROW_W]
                                      : data_in[(CHANNELS-c)*ROW_W-1 -: ROW_W];
        pooling_lane_shifter #(
            .DATA_WIDTH  (DATA_WIDTH),
            .KERNEL_SIZE (KERNEL_SIZE)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (lane_clear),
            .load     (lane_load),
            .shift    (lane_shift),
            .load_row (lane_row),
            .head     (out_data[(CHANNELS-c)*DATA_WIDTH-1 -: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_pooling_window_serializer.sv
// Directed bench for pooling_window_serializer (DATA_WIDTH=32, KERNEL_SIZE=2, CHANNELS=4).
module tb_pooling_window_serializer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_idx;
    logic [255:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [2:0]   out_idx;
    logic         out_first;
    logic         out_last;

    int tests = 0;
    int failures = 0;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F10 = 32'h41200000;
    localparam logic [31:0] F11 = 32'h41300000;
    localparam logic [31:0] F12 = 32'h41400000;
    localparam logic [31:0] F13 = 32'h41500000;

    pooling_window_serializer #(
        .DATA_WIDTH  (32),
        .KERNEL_SIZE (2),
        .CHANNELS    (4),
        .IDX_WIDTH   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Observed bundle: {valid, ready, first, last, idx, data}
    logic [134:0] obs;
    assign obs = {out_valid, in_ready, out_first, out_last, out_idx, out_data};

    function automatic logic [134:0] ex(input logic v, input logic r, input logic f,
                                        input logic l, input logic [2:0] i,
                                        input logic [127:0] d);
        return {v, r, f, l, i, d};
    endfunction

    function automatic logic [255:0] rep(input logic [31:0] w0, input logic [31:0] w1);
        return {4{w0, w1}};
    endfunction

    logic [134:0] e;

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_idx = '0; data_in = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL reset.held got %h want %h", obs, e); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== e) begin failures++; $display("FAIL reset.released got %h want %h", obs, e); end
    endtask

    task automatic test_single_row();
        in_valid = 1'b1; in_idx = 3'd5; data_in = {F1, F2, 192'h0}; out_ready = 1'b1;
        @(negedge clk);
        e = ex(1, 1, 1, 0, 5, {F1, 96'h0}); tests++;
        if (obs !== e) begin failures++; $display("FAIL single.w0 got %h want %h", obs, e); end
        in_valid = 1'b0;
        @(negedge clk);
        e = ex(1, 1, 0, 1, 5, {F2, 96'h0}); tests++;
        if (obs !== e) begin failures++; $display("FAIL single.w1 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL single.empty got %h want %h", obs, e); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; in_idx = 3'd1; data_in = rep(F1, F2);
        @(negedge clk);
        e = ex(1, 1, 1, 0, 1, {4{F1}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL b2b.a0 got %h want %h", obs, e); end
        in_idx = 3'd2; data_in = rep(F3, F4);
        @(negedge clk);
        e = ex(1, 0, 0, 1, 1, {4{F2}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL b2b.a1 got %h want %h", obs, e); end
        in_idx = 3'd3; data_in = rep(F10, F11);
        @(negedge clk);
        e = ex(1, 1, 1, 0, 2, {4{F3}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL b2b.b0 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(1, 0, 0, 1, 2, {4{F4}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL b2b.b1 got %h want %h", obs, e); end
        in_valid = 1'b0;
        @(negedge clk);
        e = ex(1, 1, 1, 0, 3, {4{F10}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL b2b.c0 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(1, 1, 0, 1, 3, {4{F11}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL b2b.c1 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL b2b.empty got %h want %h", obs, e); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; in_valid = 1'b1; in_idx = 3'd4; data_in = rep(F1, F2);
        @(negedge clk);
        e = ex(1, 1, 1, 0, 4, {4{F1}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL bp.a0 got %h want %h", obs, e); end
        in_idx = 3'd5; data_in = rep(F3, F4); out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = ex(1, 0, 1, 0, 4, {4{F1}}); tests++;
            if (obs !== e) begin
                failures++; $display("FAIL bp.stall%0d got %h want %h", k, obs, e);
            end
            in_idx = 3'd6; data_in = rep(F10, F11);
        end
        out_ready = 1'b1;
        @(negedge clk);
        e = ex(1, 0, 0, 1, 4, {4{F2}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL bp.a1 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(1, 1, 1, 0, 5, {4{F3}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL bp.b0 got %h want %h", obs, e); end
        in_valid = 1'b0;
        @(negedge clk);
        e = ex(1, 1, 0, 1, 5, {4{F4}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL bp.b1 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL bp.empty got %h want %h", obs, e); end
    endtask

    task automatic test_lane_order();
        out_ready = 1'b1; in_valid = 1'b1; in_idx = 3'd7;
        data_in = {F1, F10, F2, F11, F3, F12, F4, F13};
        @(negedge clk);
        e = ex(1, 1, 1, 0, 7, {F1, F2, F3, F4}); tests++;
        if (obs !== e) begin failures++; $display("FAIL lanes.w0 got %h want %h", obs, e); end
        in_valid = 1'b0;
        @(negedge clk);
        e = ex(1, 1, 0, 1, 7, {F10, F11, F12, F13}); tests++;
        if (obs !== e) begin failures++; $display("FAIL lanes.w1 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL lanes.empty got %h want %h", obs, e); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1; in_valid = 1'b1; in_idx = 3'd1; data_in = rep(F1, F2);
        @(negedge clk);
        e = ex(1, 1, 1, 0, 1, {4{F1}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL flush.a0 got %h want %h", obs, e); end
        in_idx = 3'd2; data_in = rep(F3, F4); out_ready = 1'b0;
        @(negedge clk);
        e = ex(1, 0, 1, 0, 1, {4{F1}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL flush.holdfull got %h want %h", obs, e); end
        flush = 1'b1; in_idx = 3'd3; data_in = rep(F10, F11);
        @(negedge clk);
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL flush.cleared got %h want %h", obs, e); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== e) begin failures++; $display("FAIL flush.residual got %h want %h", obs, e); end
        flush = 1'b1; in_valid = 1'b1; in_idx = 3'd6; data_in = rep(F12, F13);
        @(negedge clk);
        tests++;
        if (obs !== e) begin failures++; $display("FAIL flush.drop got %h want %h", obs, e); end
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== e) begin failures++; $display("FAIL flush.after got %h want %h", obs, e); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_idx = 3'd2; data_in = rep(F1, F2);
        @(negedge clk);
        e = ex(1, 1, 1, 0, 2, {4{F1}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL arst.a0 got %h want %h", obs, e); end
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL arst.immediate got %h want %h", obs, e); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_idx = 3'd3; data_in = rep(F3, F4);
        @(negedge clk);
        e = ex(1, 1, 1, 0, 3, {4{F3}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL arst.b0 got %h want %h", obs, e); end
        in_valid = 1'b0;
        @(negedge clk);
        e = ex(1, 1, 0, 1, 3, {4{F4}}); tests++;
        if (obs !== e) begin failures++; $display("FAIL arst.b1 got %h want %h", obs, e); end
        @(negedge clk);
        e = ex(0, 1, 0, 0, 0, '0); tests++;
        if (obs !== e) begin failures++; $display("FAIL arst.empty got %h want %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_backpressure();
        test_lane_order();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
